// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader and its gap timer.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BASE,
        LEN,
        DATA,
        CSUM,
        DONE,
        ERR
    } loaderState_e;

    // A LEN byte of zero stands for a full 256-byte payload.
    localparam int LEN_FULL        = 256;
    localparam int DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/gap_timer.sv
// Saturating idle-cycle counter; expired stays high once TIMEOUT idle cycles have elapsed.
module gap_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] gapCount;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gapCount <= '0;
        end else if (clear) begin
            gapCount <= '0;
        end else if (enable && !expired) begin
            gapCount <= gapCount + W'(1);
        end
    end

    assign expired = (gapCount == W'(TIMEOUT));

endmodule

// File: rtl/program_loader.sv
// Receives a framed byte stream (BASE, LEN, data, CSUM) and writes the payload
// into the program memory's write port, flagging checksum mismatch or stalls.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_start,
    input  logic              io_inValid,
    output logic              io_inReady,
    input  logic [DATA_W-1:0] io_inData,
    output logic              io_writeEnable,
    output logic [ADDR_W-1:0] io_writeAddr,
    output logic [DATA_W-1:0] io_writeData,
    output logic              io_busy,
    output logic              io_done,
    output logic              io_error,
    output logic [ADDR_W:0]   io_count
);

    localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W + 1)'(LEN_FULL);

    loaderState_e state;
    loaderState_e nextState;

    logic              accept;
    logic              active;
    logic              startArm;
    logic              lastData;
    logic              timedOut;
    logic [ADDR_W-1:0] baseAddr;
    logic [ADDR_W:0]   lenTarget;
    logic [ADDR_W:0]   countReg;
    logic [DATA_W-1:0] csum;
    logic              writeEnableReg;
    logic [ADDR_W-1:0] writeAddrReg;
    logic [DATA_W-1:0] writeDataReg;

    assign accept   = io_inValid && io_inReady;
    assign active   = (state == BASE) || (state == LEN) || (state == DATA) || (state == CSUM);
    assign startArm = io_start && ((state == IDLE) || (state == DONE) || (state == ERR));
    assign lastData = ((countReg + (ADDR_W + 1)'(1)) == lenTarget);

    gap_timer #(
        .TIMEOUT(TIMEOUT)
    ) uGapTimer (
        .clock  (clock),
        .reset  (reset),
        .clear  (accept || startArm),
        .enable (active && !accept),
        .expired(timedOut)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // An accepted byte always wins over an expiring gap timer in the same cycle.
    always_comb begin
        nextState = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (io_start) nextState = BASE;
            end
            BASE: begin
                if (accept) nextState = LEN;
                else if (timedOut) nextState = ERR;
            end
            LEN: begin
                if (accept) nextState = DATA;
                else if (timedOut) nextState = ERR;
            end
            DATA: begin
                if (accept) begin
                    if (lastData) nextState = CSUM;
                end else if (timedOut) begin
                    nextState = ERR;
                end
            end
            CSUM: begin
                if (accept) nextState = (io_inData == csum) ? DONE : ERR;
                else if (timedOut) nextState = ERR;
            end
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        io_inReady = 1'b0;
        io_busy    = writeEnableReg;
        io_done    = 1'b0;
        io_error   = 1'b0;
        case (state)
            BASE, LEN, DATA, CSUM: begin
                io_inReady = 1'b1;
                io_busy    = 1'b1;
            end
            DONE:    io_done  = 1'b1;
            ERR:     io_error = 1'b1;
            default: ;
        endcase
    end

    // Datapath: frame header capture, payload write port, running checksum.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            baseAddr       <= '0;
            lenTarget      <= '0;
            countReg       <= '0;
            csum           <= '0;
            writeEnableReg <= 1'b0;
            writeAddrReg   <= '0;
            writeDataReg   <= '0;
        end else begin
            writeEnableReg <= 1'b0;
            if (startArm) begin
                countReg <= '0;
                csum     <= '0;
            end
            case (state)
                BASE: begin
                    if (accept) baseAddr <= ADDR_W'(io_inData);
                end
                LEN: begin
                    if (accept) lenTarget <= (io_inData == '0) ? FULL_LEN : (ADDR_W + 1)'(io_inData);
                end
                DATA: begin
                    if (accept) begin
                        writeEnableReg <= 1'b1;
                        writeAddrReg   <= baseAddr + countReg[ADDR_W-1:0];
                        writeDataReg   <= io_inData;
                        csum           <= csum + io_inData;
                        countReg       <= countReg + (ADDR_W + 1)'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_writeEnable = writeEnableReg;
    assign io_writeAddr   = writeAddrReg;
    assign io_writeData   = writeDataReg;
    assign io_count       = countReg;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frame loads, wrap, bad checksum, full 256 frame,
// timeout recovery and asynchronous reset abort.
module tb_program_loader;

    localparam int TIMEOUT = 1024;

    logic       clock = 1'b0;
    logic       reset;
    logic       io_start;
    logic       io_inValid;
    logic       io_inReady;
    logic [7:0] io_inData;
    logic       io_writeEnable;
    logic [7:0] io_writeAddr;
    logic [7:0] io_writeData;
    logic       io_busy;
    logic       io_done;
    logic       io_error;
    logic [8:0] io_count;

    int testsRun  = 0;
    int failCount = 0;
    int cycle     = 0;

    logic [7:0] wAddr[$];
    logic [7:0] wData[$];
    int         wCyc[$];
    logic [7:0] memModel[256];
    logic [7:0] frame[$];

    program_loader #(
        .ADDR_W (8),
        .DATA_W (8),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .io_start      (io_start),
        .io_inValid    (io_inValid),
        .io_inReady    (io_inReady),
        .io_inData     (io_inData),
        .io_writeEnable(io_writeEnable),
        .io_writeAddr  (io_writeAddr),
        .io_writeData  (io_writeData),
        .io_busy       (io_busy),
        .io_done       (io_done),
        .io_error      (io_error),
        .io_count      (io_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle++;

    // Memory-side observer: records every write seen on the bus.
    always @(negedge clock) begin
        if (io_writeEnable) begin
            wAddr.push_back(io_writeAddr);
            wData.push_back(io_writeData);
            wCyc.push_back(cycle);
            memModel[io_writeAddr] = io_writeData;
        end
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        int n;
        @(negedge clock);
        io_inValid = 1'b1;
        io_inData  = b;
        for (n = 0; n < 50; n++) begin
            if (io_inReady) break;
            @(negedge clock);
        end
        if (n == 50) checkOutput("readyWait", 32'(io_inReady), 32'd1);
    endtask

    task automatic idle(input int n);
        @(negedge clock);
        io_inValid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic pulseStart();
        @(negedge clock);
        io_inValid = 1'b0;
        io_start   = 1'b1;
        @(negedge clock);
        io_start   = 1'b0;
    endtask

    task automatic clearLog();
        wAddr.delete();
        wData.delete();
        wCyc.delete();
    endtask

    task automatic sendFrame(input logic [7:0] bytes[$], input int maxGap);
        int g;
        foreach (bytes[i]) begin
            g = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
            if (g > 0) idle(g - 1);
            applyStimulus(bytes[i]);
        end
        idle(3);
    endtask

    initial begin
        int bad;
        reset      = 1'b0;
        io_start   = 1'b0;
        io_inValid = 1'b0;
        io_inData  = 8'h00;
        repeat (3) @(negedge clock);

        checkOutput("rstReady", 32'(io_inReady), 32'd0);
        checkOutput("rstBusy", 32'(io_busy), 32'd0);
        checkOutput("rstDone", 32'(io_done), 32'd0);
        checkOutput("rstError", 32'(io_error), 32'd0);
        checkOutput("rstWe", 32'(io_writeEnable), 32'd0);
        checkOutput("rstCount", 32'(io_count), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("idleReady", 32'(io_inReady), 32'd0);

        // Frame 1: three back-to-back payload bytes
        clearLog();
        pulseStart();
        checkOutput("t1BaseReady", 32'(io_inReady), 32'd1);
        checkOutput("t1BaseBusy", 32'(io_busy), 32'd1);
        frame = '{8'h10, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h31};
        sendFrame(frame, 0);
        checkOutput("t1Writes", 32'(wAddr.size()), 32'd3);
        if (wAddr.size() == 3) begin
            checkOutput("t1Addr0", 32'(wAddr[0]), 32'h10);
            checkOutput("t1Data0", 32'(wData[0]), 32'hAA);
            checkOutput("t1Addr1", 32'(wAddr[1]), 32'h11);
            checkOutput("t1Data1", 32'(wData[1]), 32'hBB);
            checkOutput("t1Addr2", 32'(wAddr[2]), 32'h12);
            checkOutput("t1Data2", 32'(wData[2]), 32'hCC);
            checkOutput("t1Gap01", 32'(wCyc[1] - wCyc[0]), 32'd1);
            checkOutput("t1Gap12", 32'(wCyc[2] - wCyc[1]), 32'd1);
        end
        checkOutput("t1Count", 32'(io_count), 32'd3);
        checkOutput("t1Done", 32'(io_done), 32'd1);
        checkOutput("t1Error", 32'(io_error), 32'd0);
        checkOutput("t1Busy", 32'(io_busy), 32'd0);
        checkOutput("t1Ready", 32'(io_inReady), 32'd0);

        // Frame 2: address wrap, with a stray start pulse mid-frame
        clearLog();
        pulseStart();
        checkOutput("t2DoneCleared", 32'(io_done), 32'd0);
        checkOutput("t2CountCleared", 32'(io_count), 32'd0);
        applyStimulus(8'hFE);
        applyStimulus(8'h03);
        pulseStart();
        frame = '{8'h01, 8'h02, 8'h03, 8'h06};
        sendFrame(frame, 0);
        checkOutput("t2Writes", 32'(wAddr.size()), 32'd3);
        if (wAddr.size() == 3) begin
            checkOutput("t2Addr0", 32'(wAddr[0]), 32'hFE);
            checkOutput("t2Addr1", 32'(wAddr[1]), 32'hFF);
            checkOutput("t2Addr2", 32'(wAddr[2]), 32'h00);
            checkOutput("t2Data2", 32'(wData[2]), 32'h03);
        end
        checkOutput("t2Done", 32'(io_done), 32'd1);
        checkOutput("t2Error", 32'(io_error), 32'd0);

        // Frame 3: bad checksum
        clearLog();
        pulseStart();
        frame = '{8'h00, 8'h02, 8'h05, 8'h05, 8'h00};
        sendFrame(frame, 0);
        checkOutput("t3Writes", 32'(wAddr.size()), 32'd2);
        checkOutput("t3Error", 32'(io_error), 32'd1);
        checkOutput("t3Done", 32'(io_done), 32'd0);
        checkOutput("t3Count", 32'(io_count), 32'd2);
        checkOutput("t3Mem1", 32'(memModel[1]), 32'h05);

        // Frame 4: LEN=0 means 256 bytes
        clearLog();
        pulseStart();
        checkOutput("t4ErrorCleared", 32'(io_error), 32'd0);
        frame = '{8'h00, 8'h00};
        for (int i = 0; i < 256; i++) frame.push_back(8'(i));
        frame.push_back(8'h80);
        sendFrame(frame, 0);
        checkOutput("t4Writes", 32'(wAddr.size()), 32'd256);
        checkOutput("t4Count", 32'(io_count), 32'd256);
        checkOutput("t4Done", 32'(io_done), 32'd1);
        checkOutput("t4Error", 32'(io_error), 32'd0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (memModel[i] !== 8'(i)) bad++;
        checkOutput("t4MemImage", 32'(bad), 32'd0);
        bad = 0;
        for (int i = 1; i < wCyc.size(); i++) if (wCyc[i] - wCyc[i-1] != 1) bad++;
        checkOutput("t4BackToBack", 32'(bad), 32'd0);

        // Frame 5: stall after one data byte times out
        clearLog();
        pulseStart();
        applyStimulus(8'h20);
        applyStimulus(8'h04);
        applyStimulus(8'h07);
        idle(TIMEOUT / 2);
        checkOutput("t5NoEarlyTimeout", 32'(io_error), 32'd0);
        idle(TIMEOUT / 2 + 5);
        checkOutput("t5Error", 32'(io_error), 32'd1);
        checkOutput("t5Done", 32'(io_done), 32'd0);
        checkOutput("t5Ready", 32'(io_inReady), 32'd0);
        checkOutput("t5Count", 32'(io_count), 32'd1);
        checkOutput("t5Mem20", 32'(memModel[8'h20]), 32'h07);
        clearLog();
        pulseStart();
        checkOutput("t5ErrorCleared", 32'(io_error), 32'd0);
        checkOutput("t5CountCleared", 32'(io_count), 32'd0);
        frame = '{8'h10, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h31};
        sendFrame(frame, 0);
        checkOutput("t5ReloadDone", 32'(io_done), 32'd1);
        checkOutput("t5ReloadWrites", 32'(wAddr.size()), 32'd3);

        // Frame 6: asynchronous reset in the middle of DATA
        memModel[8'h10] = 8'h00;
        memModel[8'h11] = 8'h00;
        memModel[8'h12] = 8'h00;
        pulseStart();
        applyStimulus(8'h10);
        applyStimulus(8'h03);
        applyStimulus(8'hAA);
        applyStimulus(8'hBB);
        @(posedge clock);
        #1;
        checkOutput("t6WeBeforeReset", 32'(io_writeEnable), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("t6WeAsync", 32'(io_writeEnable), 32'd0);
        checkOutput("t6ReadyIdle", 32'(io_inReady), 32'd0);
        checkOutput("t6BusyIdle", 32'(io_busy), 32'd0);
        checkOutput("t6Count", 32'(io_count), 32'd0);
        @(negedge clock);
        checkOutput("t6HeldReset", 32'(io_writeEnable), 32'd0);
        checkOutput("t6PartialKept", 32'(memModel[8'h10]), 32'hAA);
        io_inValid = 1'b0;
        reset      = 1'b1;
        @(negedge clock);
        checkOutput("t6IdleAfter", 32'(io_inReady), 32'd0);

        clearLog();
        memModel[8'h10] = 8'h00;
        memModel[8'h11] = 8'h00;
        pulseStart();
        frame = '{8'h10, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h31};
        sendFrame(frame, 6);
        checkOutput("t6GapWrites", 32'(wAddr.size()), 32'd3);
        checkOutput("t6GapMem10", 32'(memModel[8'h10]), 32'hAA);
        checkOutput("t6GapMem11", 32'(memModel[8'h11]), 32'hBB);
        checkOutput("t6GapMem12", 32'(memModel[8'h12]), 32'hCC);
        checkOutput("t6GapDone", 32'(io_done), 32'd1);
        checkOutput("t6GapCount", 32'(io_count), 32'd3);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
